// File: rtl/bcd_to_dec_serializer.sv
// Serialises a packed BCD word into one-hot decimal lamp codes, most significant digit first,
// with valid/ready handshakes on both sides and every output driven straight from a flop.
module bcd_to_dec_serializer #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   In,
  input  logic                  In_valid,
  output logic                  In_ready,
  output logic [9:0]            Out,
  output logic [2:0]            Out_idx,
  output logic                  Out_err,
  output logic                  Out_last,
  output logic                  Word_err,
  output logic                  Out_valid,
  input  logic                  Out_ready
);

  localparam int W = 4 * DIGITS;

  typedef enum logic {IDLE, SEND} state_t;

  state_t         state_q;
  logic [W-1:0]   sr_q, sr_d;
  logic [2:0]     cnt_q, cnt_d;
  logic           sticky_q, sticky_d;
  logic [9:0]     out_q;
  logic           err_q, last_q, werr_q, valid_q, ready_q;
  logic [3:0]     nib_in, nib_d;

  function automatic logic [9:0] bcd_onehot(input logic [3:0] n);
    return (n <= 4'd9) ? (10'd1 << n) : 10'd0;
  endfunction

  // Codes 10..14 are illegal; 15 is the legal "blank" code.
  function automatic logic bcd_illegal(input logic [3:0] n);
    return (n >= 4'd10) && (n != 4'hF);
  endfunction

  always_comb begin
    sr_d     = sr_q << 4;
    cnt_d    = cnt_q - 3'd1;
    sticky_d = sticky_q | err_q;
    nib_in   = In[W-1 -: 4];
    nib_d    = sr_d[W-1 -: 4];
  end

  // Outputs are precomputed for the digit that will be on display after the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      out_q    <= '0;
      err_q    <= 1'b0;
      last_q   <= 1'b0;
      werr_q   <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (In_valid && ready_q) begin
            state_q  <= SEND;
            sr_q     <= In;
            cnt_q    <= 3'(DIGITS - 1);
            sticky_q <= 1'b0;
            out_q    <= bcd_onehot(nib_in);
            err_q    <= bcd_illegal(nib_in);
            last_q   <= (DIGITS == 1);
            werr_q   <= bcd_illegal(nib_in);
            valid_q  <= 1'b1;
            ready_q  <= 1'b0;
          end else begin
            ready_q  <= 1'b1;
          end
        end
        SEND: begin
          if (Out_ready) begin
            if (cnt_q == 3'd0) begin
              state_q <= IDLE;
              out_q   <= '0;
              err_q   <= 1'b0;
              last_q  <= 1'b0;
              werr_q  <= 1'b0;
              valid_q <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              sr_q     <= sr_d;
              cnt_q    <= cnt_d;
              sticky_q <= sticky_d;
              out_q    <= bcd_onehot(nib_d);
              err_q    <= bcd_illegal(nib_d);
              last_q   <= (cnt_d == 3'd0);
              werr_q   <= sticky_d | bcd_illegal(nib_d);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign In_ready  = ready_q;
  assign Out       = out_q;
  assign Out_idx   = cnt_q;
  assign Out_err   = err_q;
  assign Out_last  = last_q;
  assign Word_err  = werr_q;
  assign Out_valid = valid_q;

endmodule

// File: tb/tb_bcd_to_dec_serializer.sv
// Bench for bcd_to_dec_serializer (DIGITS=4): directed cases plus random words and random backpressure.
module tb_bcd_to_dec_serializer;

  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4*D-1:0] In = '0;
  logic          In_valid = 1'b0;
  logic          In_ready;
  logic [9:0]    Out;
  logic [2:0]    Out_idx;
  logic          Out_err, Out_last, Word_err, Out_valid;
  logic          Out_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  bcd_to_dec_serializer #(.DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .In(In), .In_valid(In_valid), .In_ready(In_ready),
    .Out(Out), .Out_idx(Out_idx), .Out_err(Out_err), .Out_last(Out_last),
    .Word_err(Word_err), .Out_valid(Out_valid), .Out_ready(Out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

  // Reference for one beat: digit value -> {one-hot, illegal flag}, from the code table.
  function automatic logic [10:0] ref_digit(input logic [3:0] d);
    logic [9:0] oh;
    oh = (d <= 4'd9) ? (10'd1 << d) : 10'd0;
    return {oh, (d >= 4'd10 && d <= 4'd14)};
  endfunction

  // Presents w, then checks every beat. Beat stall_idx is held off for stall_n cycles;
  // other beats are stalled randomly with probability rand_pct percent.
  task automatic send_word(input logic [15:0] w, input int rand_pct, input int stall_idx,
                           input int stall_n);
    logic [3:0]  d;
    logic [10:0] rd;
    logic        ew, accepted;
    logic [16:0] exp_v, act_v;
    int waitc, stalls, guard;
    ew = 1'b0;
    for (int i = 0; i < D; i++) begin
      d = w[4*i +: 4];
      rd = ref_digit(d);
      if (rd[0]) ew = 1'b1;
    end
    Out_ready = 1'b0;
    In = w;
    In_valid = 1'b1;
    waitc = 0;
    while (In_ready !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    tests++;
    if (In_ready !== 1'b1) begin
      fails++;
      $display("FAIL capture_wait word=%h In_ready=%b required 1", w, In_ready);
      In_valid = 1'b0;
      return;
    end
    @(negedge clk);
    In_valid = 1'b0;
    In = $urandom;
    for (int i = D - 1; i >= 0; i--) begin
      d = w[4*i +: 4];
      rd = ref_digit(d);
      stalls = (i == stall_idx) ? stall_n : 0;
      guard = 0;
      accepted = 1'b0;
      do begin
        exp_v = {1'b1, rd[10:1], 3'(i), rd[0], (i == 0), (i == 0) ? ew : 1'b0, 1'b0};
        act_v = {Out_valid, Out, Out_idx, Out_err, Out_last, (i == 0) ? Word_err : 1'b0, In_ready};
        tests++;
        if (act_v !== exp_v) begin
          fails++;
          $display("FAIL beat word=%h idx=%0d got valid=%b out=%h idx=%0d err=%b last=%b werr=%b rdy=%b required %b %h %0d %b %b %b 0",
                   w, i, act_v[16], act_v[15:6], act_v[5:3], act_v[2], act_v[1], Word_err, act_v[0],
                   exp_v[16], exp_v[15:6], exp_v[5:3], exp_v[2], exp_v[1], ew);
        end
        if (stalls > 0) begin
          Out_ready = 1'b0;
          stalls--;
        end else if (rand_pct > 0 && guard < 6 && $urandom_range(99) < rand_pct) begin
          Out_ready = 1'b0;
          guard++;
        end else begin
          Out_ready = 1'b1;
          accepted = 1'b1;
        end
        @(negedge clk);
      end while (!accepted);
    end
    tests++;
    if (Out_valid !== 1'b0 || In_ready !== 1'b1) begin
      fails++;
      $display("FAIL word_done word=%h Out_valid=%b In_ready=%b required 0 1", w, Out_valid, In_ready);
    end
    Out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++;
    if ({In_ready, Out, Out_idx, Out_err, Out_last, Word_err, Out_valid} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got %b required all zero",
               {In_ready, Out, Out_idx, Out_err, Out_last, Word_err, Out_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (In_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_before_edge In_ready=%b required 0", In_ready);
    end
    @(negedge clk);
    tests++;
    if (In_ready !== 1'b1 || Out_valid !== 1'b0) begin
      fails++;
      $display("FAIL ready_after_edge In_ready=%b Out_valid=%b required 1 0", In_ready, Out_valid);
    end
  endtask

  task automatic test_basic();
    send_word(16'h1905, 0, -1, 0);
    send_word(16'hF0A7, 0, -1, 0);
  endtask

  task automatic test_backpressure();
    send_word(16'h2468, 0, 2, 3);
  endtask

  task automatic test_busy_input();
    logic [9:0] eo;
    Out_ready = 1'b1;
    In = 16'h1111;
    In_valid = 1'b1;
    @(negedge clk);
    In = 16'h9999;
    for (int w = 0; w < 2; w++) begin
      eo = (w == 0) ? 10'h002 : 10'h200;
      for (int i = D - 1; i >= 0; i--) begin
        tests++;
        if ({Out_valid, Out, Out_idx, In_ready} !== {1'b1, eo, 3'(i), 1'b0}) begin
          fails++;
          $display("FAIL busy_beat word=%0d idx=%0d got v=%b out=%h idx=%0d rdy=%b required 1 %h %0d 0",
                   w, i, Out_valid, Out, Out_idx, In_ready, eo, i);
        end
        @(negedge clk);
      end
      tests++;
      if (Out_valid !== 1'b0 || In_ready !== 1'b1) begin
        fails++;
        $display("FAIL busy_gap word=%0d Out_valid=%b In_ready=%b required 0 1", w, Out_valid, In_ready);
      end
      if (w == 0) @(negedge clk);
      else In_valid = 1'b0;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++;
      if (Out_valid !== 1'b0) begin
        fails++;
        $display("FAIL busy_extra cycle=%0d Out_valid=%b required 0", c, Out_valid);
      end
    end
    Out_ready = 1'b0;
  endtask

  task automatic test_reset_midword();
    Out_ready = 1'b1;
    In = 16'h1234;
    In_valid = 1'b1;
    @(negedge clk);
    In_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    Out_ready = 1'b0;
    tests++;
    if (Out_idx !== 3'd1 || Out !== 10'h008) begin
      fails++;
      $display("FAIL midword_pos Out_idx=%0d Out=%h required 1 008", Out_idx, Out);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({In_ready, Out, Out_idx, Out_err, Out_last, Word_err, Out_valid} !== '0) begin
      fails++;
      $display("FAIL midword_reset got %b required all zero",
               {In_ready, Out, Out_idx, Out_err, Out_last, Word_err, Out_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    Out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (Out_valid !== 1'b0 || In_ready !== 1'b1) begin
      fails++;
      $display("FAIL after_reset Out_valid=%b In_ready=%b required 0 1", Out_valid, In_ready);
    end
    send_word(16'h5678, 0, -1, 0);
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < D; i++)
        w[4*i +: 4] = ($urandom_range(3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(9));
      send_word(w, 35, -1, 0);
      repeat ($urandom_range(2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_busy_input();
    test_reset_midword();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_to_dec_serializer.md
# bcd_to_dec_serializer

Serialises a packed multi-digit BCD word into one-hot decimal lamp/keypad codes, one digit per beat, over valid/ready handshakes on both sides. It is the inverse of the keypad decimal-to-BCD encoder: bit k of the one-hot output means digit k, code 4'b1111 means blank (all lamps off), and codes 4'b1010–4'b1110 are flagged as errors. It sits between the BCD display or number path and the 10-line decimal indicator bank.

## Interface
- DIGITS, default 4: number of BCD digits per input word (legal range 1–8).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- In  in  4*DIGITS  packed BCD word; digit i occupies In[4i+3:4i], and digit DIGITS-1 is the most significant.
- In_valid  in  1  In is presented.
- In_ready  out  1  block can capture a word.
- Out  out  10  one-hot decimal code for the current digit.
- Out_idx  out  3  position of the current digit (DIGITS-1 down to 0).
- Out_err  out  1  current digit is an illegal code (10–14).
- Out_last  out  1  current beat is digit 0.
- Word_err  out  1  with Out_last: at least one digit of this word was illegal.
- Out_valid  out  1  Out and its qualifiers are valid.
- Out_ready  in  1  downstream accepts the beat.

## Operation
- The FSM has two states, IDLE and SEND. All outputs come from registers, so there is no combinational path from In or In_valid to any output.
- IDLE: In_ready=1 and Out_valid=0. When In_valid && In_ready, the block captures In into a shift register, sets the digit counter to DIGITS-1, clears the sticky error bit, and goes to SEND.
- SEND: In_ready=0 and Out_valid=1. Out is the decode of the top nibble of the shift register:
  - 0 -> 10'b0000000001
  - k in 1–9 -> 10'b1 << k
  - 4'b1111 -> 10'b0000000000 (blank, Out_err=0)
  - 10–14 -> 10'b0000000000 with Out_err=1
- A beat completes when Out_valid && Out_ready:
  - If the counter is 0, go to IDLE.
  - Otherwise shift the register left by 4, decrement the counter, and OR the current Out_err into the sticky bit.
- Word_err = sticky | Out_err, and is meaningful only while Out_last=1. Out_last = (counter==0).
- When Out_valid=1 and Out_ready=0, Out, Out_idx, Out_err, Out_last and Word_err hold stable. Beats are never skipped or duplicated.
- In is ignored whenever In_ready=0, including while In_valid is held high.

## Timing
- Reset (rst_n low): state is IDLE and all outputs are 0, including In_ready, Out, Out_idx, Out_err, Out_last, Word_err and Out_valid. Any word in flight is discarded immediately.
- In_ready rises at the first rising clock edge after rst_n deasserts. It is a registered signal.
- Capture at edge T gives Out_valid=1 after edge T, carrying the most significant digit (latency 1 cycle).
- With Out_ready held at 1, the block emits one beat per cycle. Digit 0 is presented DIGITS-1 cycles after the first beat.
- After the final beat is accepted at edge E: Out_valid=0 and In_ready=1 after E. The next word can be captured at edge E+1. Throughput is DIGITS+1 cycles per word.
- Reset asserted mid-word: outputs clear asynchronously. After release, the next captured word starts again from Out_idx=DIGITS-1.
- There is no simultaneous capture and emit, because In_ready and Out_valid are never both 1.

## Test plan
- Reset: assert rst_n=0 mid-simulation -> all outputs are 0 immediately; after release, In_ready=0 until the first edge, then 1.
- DIGITS=4, In=16'h1905 with Out_ready=1 -> four consecutive beats:
  - Out = 10'h002, 10'h200, 10'h001, 10'h020
  - Out_idx = 3, 2, 1, 0
  - Out_last only on the 4th beat, with Word_err=0
  - In_ready=1 on the cycle after the 4th beat
- In=16'hF0A7 -> beats:
  - 10'h000 with Out_err=0
  - 10'h001 with Out_err=0
  - 10'h000 with Out_err=1
  - 10'h080 with Out_err=0
  - Word_err=1 on the last beat
- Backpressure: In=16'h2468, with Out_ready=0 for 3 cycles during beat idx 2 -> Out stays 10'h010 for all 3 cycles; the beat sequence is exactly 10'h004, 10'h010, 10'h040, 10'h100.
- Busy input: In_valid held high with word A=16'h1111, then B=16'h9999 presented while A is in SEND -> A is emitted once, then B is captured exactly once after A's last beat, and nothing else is accepted.
- Reset after 2 accepted beats of 16'h1234 -> no further beats; after release, word 16'h5678 emits 10'h020, 10'h040, 10'h080, 10'h100 starting at Out_idx=3.
